// File: rtl/seg7_pkg.sv
// Shared constants and hex-to-segment table for the 7-segment scan driver.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF    = 8'hFF;
    localparam int         SEG_DP_BIT = 7;
    localparam logic [6:0] SEGS_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; dp is handled separately.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    assign segs = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed N-digit 7-segment driver with double-buffered image loads,
// leading-zero suppression, dead-time and PWM brightness.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int N_DIGITS   = 8,
    parameter int SCAN_DIV_W = 17,
    parameter int BRIGHT_W   = 3,
    parameter int DEAD_CYC   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] data_i,
    input  logic [N_DIGITS-1:0]   dp_i,
    input  logic [N_DIGITS-1:0]   blank_i,
    input  logic                  lz_supp_i,
    input  logic [BRIGHT_W-1:0]   bright_i,
    input  logic                  load_valid_i,
    output logic                  load_ready_o,
    output logic                  frame_o,
    output logic [7:0]            SEG,
    output logic [N_DIGITS-1:0]   AN
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    logic [SCAN_DIV_W-1:0] presc;
    logic [IDX_W-1:0]      idx;
    logic                  pending;

    logic [N_DIGITS-1:0][3:0] sh_data, act_data;
    logic [N_DIGITS-1:0]      sh_dp, sh_blank, act_dp, act_blank;
    logic                     sh_lz, act_lz;
    logic [BRIGHT_W-1:0]      sh_bright, act_bright;

    logic tick, boundary, accept;

    assign tick         = &presc;
    assign boundary     = tick && (idx == LAST_IDX);
    assign accept       = load_valid_i && !pending;
    assign load_ready_o = !pending;
    assign frame_o      = boundary;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            idx        <= '0;
            pending    <= 1'b0;
            sh_data    <= '0;
            sh_dp      <= '0;
            sh_blank   <= '0;
            sh_lz      <= 1'b0;
            sh_bright  <= '0;
            act_data   <= '0;
            act_dp     <= '0;
            act_blank  <= '1;
            act_lz     <= 1'b0;
            act_bright <= '0;
        end else begin
            presc <= presc + 1'b1;
            if (tick)
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            // Accept needs !pending, so it can never collide with a commit.
            if (accept) begin
                sh_data   <= data_i;
                sh_dp     <= dp_i;
                sh_blank  <= blank_i;
                sh_lz     <= lz_supp_i;
                sh_bright <= bright_i;
                pending   <= 1'b1;
            end else if (boundary && pending) begin
                act_data   <= sh_data;
                act_dp     <= sh_dp;
                act_blank  <= sh_blank;
                act_lz     <= sh_lz;
                act_bright <= sh_bright;
                pending    <= 1'b0;
            end
        end
    end

    // above[k]: every digit left of k is zero or blanked.
    logic [N_DIGITS-1:0] above, supp;
    logic                run;

    always_comb begin
        above = '0;
        run   = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            above[k] = run;
            run      = run & ((act_data[k] == 4'h0) | act_blank[k]);
        end
    end

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_supp
        if (k == 0) begin : g_d0
            assign supp[k] = 1'b0;
        end else begin : g_dk
            assign supp[k] = act_lz && (act_data[k] == 4'h0) && above[k];
        end
    end

    logic [3:0]          cur_nib;
    logic [6:0]          dec_segs;
    logic                cur_dark, lit;
    logic [7:0]          seg_next;
    logic [N_DIGITS-1:0] one_hot;

    assign cur_nib = act_data[idx];

    seg7_hex_decode u_dec (
        .nibble (cur_nib),
        .segs   (dec_segs)
    );

    // A suppressed digit stays lit only to show its decimal point.
    assign cur_dark = act_blank[idx] || (supp[idx] && !act_dp[idx]);
    assign seg_next = cur_dark ? SEG_OFF
                               : {~act_dp[idx], supp[idx] ? SEGS_BLANK : dec_segs};
    assign lit      = !cur_dark && (presc >= SCAN_DIV_W'(DEAD_CYC)) &&
                      ((&act_bright) || (presc[SCAN_DIV_W-1 -: BRIGHT_W] < act_bright));
    assign one_hot  = N_DIGITS'(1) << idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SEG <= SEG_OFF;
            AN  <= '1;
        end else begin
            SEG <= seg_next;
            AN  <= lit ? ~one_hot : '1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench: transaction-level display model predicts pins every cycle.
module tb_seg7_scan_display;

    localparam int N  = 4;
    localparam int SW = 4;
    localparam int BW = 2;
    localparam int DC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp = '0, blank = '0;
    logic        lz = 1'b0;
    logic [1:0]  bright = '0;
    logic        valid = 1'b0;
    logic        load_ready_o, frame_o;
    logic [7:0]  SEG;
    logic [3:0]  AN;

    int checks = 0;
    int errors = 0;

    seg7_scan_display #(.N_DIGITS(N), .SCAN_DIV_W(SW), .BRIGHT_W(BW), .DEAD_CYC(DC)) dut (
        .clk(clk), .rst_n(rst_n), .data_i(data), .dp_i(dp), .blank_i(blank),
        .lz_supp_i(lz), .bright_i(bright), .load_valid_i(valid),
        .load_ready_o(load_ready_o), .frame_o(frame_o), .SEG(SEG), .AN(AN)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rdy;
        logic       frm;
        logic [7:0] seg;
        logic [3:0] an;
    } exp_t;

    exp_t exp_q[$];

    logic [7:0] seg_tbl[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // What the pins should show for one image at slot ix, slot-cycle p.
    function automatic logic [11:0] disp(logic [15:0] d, logic [3:0] dpv, logic [3:0] bl,
                                         logic lzv, logic [1:0] br, int p, int ix);
        int nib, nj;
        bit allz, sup, on;
        logic [6:0] s7;
        logic [3:0] oh;
        nib  = (d >> (4 * ix)) & 15;
        allz = 1;
        for (int j = ix + 1; j < N; j++) begin
            nj = (d >> (4 * j)) & 15;
            if (nj != 0 && !bl[j]) allz = 0;
        end
        sup = lzv && ix != 0 && nib == 0 && allz;
        if (bl[ix] || (sup && !dpv[ix])) return {8'hFF, 4'hF};
        s7 = sup ? 7'h7F : seg_tbl[nib][6:0];
        on = (p >= DC) && (br == 3 || (p / 4) < br);
        oh = 4'b0001 << ix;
        return {~dpv[ix], s7, on ? ~oh : 4'hF};
    endfunction

    // Reference model: frames of 64 cycles, images commit at the first frame end after acceptance.
    int          mcyc;
    logic        m_pend;
    logic [15:0] a_d, s_d;
    logic [3:0]  a_dp, a_bl, s_dp, s_bl;
    logic        a_lz, s_lz;
    logic [1:0]  a_br, s_br;
    logic [11:0] nxt;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mcyc = 0; m_pend = 0;
                a_d = '0; a_dp = '0; a_bl = 4'hF; a_lz = 0; a_br = '0;
                s_d = '0; s_dp = '0; s_bl = '0; s_lz = 0; s_br = '0;
                nxt = {8'hFF, 4'hF};
                exp_q.push_back('{rdy: 1'b1, frm: 1'b0, seg: 8'hFF, an: 4'hF});
            end else begin
                int p, ix;
                bit frm;
                p   = mcyc % 16;
                ix  = (mcyc / 16) % N;
                frm = (mcyc % 64) == 63;
                exp_q.push_back('{rdy: !m_pend, frm: frm, seg: nxt[11:4], an: nxt[3:0]});
                nxt = disp(a_d, a_dp, a_bl, a_lz, a_br, p, ix);
                if (valid && !m_pend) begin
                    s_d = data; s_dp = dp; s_bl = blank; s_lz = lz; s_br = bright;
                    m_pend = 1;
                end else if (frm && m_pend) begin
                    a_d = s_d; a_dp = s_dp; a_bl = s_bl; a_lz = s_lz; a_br = s_br;
                    m_pend = 0;
                end
                mcyc++;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({load_ready_o, frame_o, SEG, AN} !== e) begin
                    errors++;
                    $display("FAIL pins t=%0t got rdy=%b frm=%b seg=%h an=%h exp rdy=%b frm=%b seg=%h an=%h",
                             $time, load_ready_o, frame_o, SEG, AN, e.rdy, e.frm, e.seg, e.an);
                end
            end
        end
    end

    task automatic load(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] bl,
                        input logic lzv, input logic [1:0] br);
        int n;
        @(posedge clk); #1;
        data = d; dp = dpv; blank = bl; lz = lzv; bright = br; valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (load_ready_o) break;
            n++;
            if (n > 300) break;
        end
        checks++;
        if (n > 300) begin
            errors++;
            $display("FAIL handshake got ready=0 for 300 cycles exp ready=1 data=%h", d);
        end
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog got no end of stimulus exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cycles(3);
        #1 rst_n = 1'b1;
        cycles(140);
        load(16'h12AF, 4'h0, 4'h0, 1'b0, 2'd3);
        cycles(200);
        // Second image offered while first is pending.
        load(16'h1111, 4'h0, 4'h0, 1'b0, 2'd3);
        load(16'h2222, 4'h0, 4'h0, 1'b0, 2'd3);
        cycles(200);
        // Offer lands exactly on the frame-boundary cycle.
        forever begin
            @(negedge clk); #2;
            if (mcyc % 64 == 63) break;
        end
        load(16'h0042, 4'h0, 4'h0, 1'b0, 2'd3);
        cycles(150);
        load(16'h0040, 4'h0, 4'h0, 1'b1, 2'd3);
        cycles(140);
        load(16'h0000, 4'h0, 4'h0, 1'b1, 2'd3);
        cycles(140);
        load(16'h0305, 4'b0100, 4'h0, 1'b1, 2'd3);
        cycles(140);
        load(16'h12AF, 4'h0, 4'h0, 1'b0, 2'd1);
        cycles(140);
        load(16'h12AF, 4'h0, 4'h0, 1'b0, 2'd0);
        cycles(140);
        load(16'h12AF, 4'hF, 4'b0010, 1'b0, 2'd2);
        cycles(140);
        for (int i = 0; i < 24; i++) begin
            logic [15:0] d;
            for (int k = 0; k < 4; k++)
                d[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            load(d, 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0),
                 1'($urandom), 2'($urandom));
            cycles($urandom_range(0, 100));
        end
        // Asynchronous reset in the middle of a slot.
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (SEG !== 8'hFF || AN !== 4'hF || load_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got seg=%h an=%h rdy=%b exp seg=ff an=f rdy=1",
                     SEG, AN, load_ready_o);
        end
        cycles(3);
        #1 rst_n = 1'b1;
        cycles(200);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
